// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate extender.
// The result struct is sized for the widest datapath; narrower instances
// zero the unused upper bits and only consume value[XLEN-1:0].
package imm_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_J   = 3'd3,
    IMM_U   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_ILL = 3'd7
  } imm_src_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] value;
    logic                illegal;
  } imm_result_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for every RV32/RV64 format, including
// the CSR zimm and shift-amount fields. Selector 111 flags illegal.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]  i_instr,
  input  logic [2:0]   i_immsrc,
  output imm_result_t  o_result
);

  // Shift-amount width follows the datapath width.
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic        w_s;
  logic [63:0] w_full;
  logic        w_ill;

  assign w_s = i_instr[31];

  // Build the 64-bit extended immediate for the selected format.
  always_comb begin
    w_full = '0;
    w_ill  = 1'b0;
    case (imm_src_e'(i_immsrc))
      IMM_I:   w_full = {{52{w_s}}, i_instr[31:20]};
      IMM_S:   w_full = {{52{w_s}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_full = {{51{w_s}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
      IMM_J:   w_full = {{43{w_s}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
      IMM_U:   w_full = {{32{w_s}}, i_instr[31:12], 12'b0};
      IMM_Z:   w_full = {59'b0, i_instr[19:15]};
      IMM_SH:  w_full = {58'b0, (SHAMT_W == 6) ? i_instr[25] : 1'b0, i_instr[24:20]};
      IMM_ILL: w_ill  = 1'b1;
    endcase
  end

  // Narrow datapaths carry zeros above bit 31 so the struct is fully defined.
  always_comb begin
    o_result.illegal = w_ill;
    if (XLEN == 64) o_result.value = w_full;
    else            o_result.value = {32'b0, w_full[31:0]};
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: decode feeds an output register backed by
// a one-entry skid register, so in_ready never depends on out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, holds its payload stable until accepted;
// ready may change freely and is never derived combinationally from the
// opposite side's ready.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  imm_result_t     w_dec;
  logic            w_in_fire;
  logic            w_out_adv;
  logic            w_unused_dec;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic            r_out_ill;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_skid_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr  (instr),
    .i_immsrc (immsrc),
    .o_result (w_dec)
  );

  // Upper struct bits are zero for narrow instances and intentionally dropped.
  assign w_unused_dec = ^w_dec.value;

  // Ready comes straight from the skid flop; no path from out_ready.
  assign in_ready  = ~r_skid_valid;
  assign w_in_fire = in_valid & ~r_skid_valid;
  // Output stage can take new data when empty or being consumed this cycle.
  assign w_out_adv = ~r_out_valid | out_ready;

  assign out_valid = r_out_valid;
  assign immext    = r_out_imm;
  assign illegal   = r_out_ill;

  // Output stage: prefer the older skid entry, then a fresh input, else empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_ill   <= 1'b0;
    end else if (w_out_adv) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= r_skid_imm;
        r_out_ill   <= r_skid_ill;
      end else if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_dec.value[XLEN-1:0];
        r_out_ill   <= w_dec.illegal;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: catch an accepted input the output stage cannot take now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_ill   <= 1'b0;
    end else if (w_in_fire && (!w_out_adv || r_skid_valid)) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_dec.value[XLEN-1:0];
      r_skid_ill   <= w_dec.illegal;
    end else if (w_out_adv) begin
      r_skid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one 32-bit and one 64-bit instance
// share all inputs and are checked side by side.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:7] instr;
  logic [2:0]  immsrc;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] immext32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] immext64;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q32[$];
  logic [63:0] exp_q64[$];
  logic [0:0]  ill_q[$];

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid32),
    .out_ready(out_ready), .immext(immext32), .illegal(illegal32)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid64),
    .out_ready(out_ready), .immext(immext64), .illegal(illegal64)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] w);
    in_valid = 1'b1;
    immsrc   = src;
    instr    = w[31:7];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    immsrc   = $urandom_range(0, 7);
    instr    = 25'($urandom());
  endtask

  // Compare both instances' output stage against expected values.
  task automatic chk_out(input string tag, input logic ev, input logic [31:0] e32,
                         input logic [63:0] e64, input logic eill);
    chk({tag, "_valid32"}, {63'b0, out_valid32}, {63'b0, ev});
    chk({tag, "_valid64"}, {63'b0, out_valid64}, {63'b0, ev});
    chk({tag, "_imm32"}, {32'b0, immext32}, {32'b0, e32});
    chk({tag, "_imm64"}, immext64, e64);
    chk({tag, "_ill32"}, {63'b0, illegal32}, {63'b0, eill});
    chk({tag, "_ill64"}, {63'b0, illegal64}, {63'b0, eill});
  endtask

  task automatic chk_rdy(input string tag, input logic er);
    chk({tag, "_rdy32"}, {63'b0, in_ready32}, {63'b0, er});
    chk({tag, "_rdy64"}, {63'b0, in_ready64}, {63'b0, er});
  endtask

  // Reference model: gather the raw field, then sign-extend by shifting.
  task automatic ref_imm(input logic [31:0] w, input logic [2:0] src, input bit is64,
                         output logic [63:0] v, output logic ill);
    logic [63:0]        raw;
    logic signed [63:0] t;
    int                 wd;
    bit                 sgn;
    raw = '0; wd = 1; sgn = 1'b1; ill = 1'b0;
    case (src)
      3'd0: begin raw = 64'(w[31:20]); wd = 12; end
      3'd1: begin raw = 64'({w[31:25], w[11:7]}); wd = 12; end
      3'd2: begin raw = 64'({w[31], w[7], w[30:25], w[11:8], 1'b0}); wd = 13; end
      3'd3: begin raw = 64'({w[31], w[19:12], w[20], w[30:21], 1'b0}); wd = 21; end
      3'd4: begin raw = 64'({w[31:12], 12'b0}); wd = 32; end
      3'd5: begin raw = 64'(w[19:15]); sgn = 1'b0; end
      3'd6: begin raw = 64'(w[25:20]) & (is64 ? 64'h3F : 64'h1F); sgn = 1'b0; end
      default: begin raw = '0; sgn = 1'b0; ill = 1'b1; end
    endcase
    if (sgn) begin
      t = raw << (64 - wd);
      t = t >>> (64 - wd);
      v = t;
    end else begin
      v = raw;
    end
  endtask

  // Send one item with out_ready=1, check it, let it drain.
  task automatic one(input string tag, input logic [2:0] src, input logic [31:0] w,
                     input logic [31:0] e32, input logic [63:0] e64, input logic eill);
    drive(src, w);
    cyc();
    idle();
    chk_out(tag, 1'b1, e32, e64, eill);
    cyc();
  endtask

  initial begin
    logic [63:0] v64, v32;
    logic        il, il32;
    logic [31:0] w;
    logic [2:0]  src;

    // Reset state with downstream stalled
    reset = 1'b1; out_ready = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 64'h0, 1'b0);
    chk_rdy("reset", 1'b1);
    reset = 1'b0;
    cyc();

    // First I-type result, one-cycle latency
    drive(3'd0, 32'hFFF0_0000);
    cyc();
    idle();
    chk_out("first_i", 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk_out("drained", 1'b0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Format sweep
    one("u_neg",   3'd4, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    one("sh_3f",   3'd6, 32'h03F0_0000, 32'h0000_001F, 64'h0000_0000_0000_003F, 1'b0);
    one("z_1f",    3'd5, 32'h000F_8000, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    one("b_sign",  3'd2, 32'h8000_0000, 32'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
    one("s_neg1",  3'd1, 32'hFE00_0F80, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    one("i_pos",   3'd0, 32'h7FF0_0000, 32'h0000_07FF, 64'h0000_0000_0000_07FF, 1'b0);
    one("illegal", 3'd7, 32'hFFFF_FFFF, 32'h0,         64'h0,                   1'b1);
    one("j_two",   3'd3, 32'h0020_0000, 32'h0000_0002, 64'h0000_0000_0000_0002, 1'b0);

    // Backpressure: A fills output, B fills skid, C is refused
    out_ready = 1'b0;
    drive(3'd0, 32'h1230_0000);
    cyc();
    chk_rdy("bp_after_a", 1'b1);
    drive(3'd1, 32'h0200_0100);
    cyc();
    chk_rdy("bp_after_b", 1'b0);
    chk_out("bp_hold_a", 1'b1, 32'h123, 64'h123, 1'b0);
    drive(3'd0, 32'h4560_0000);
    cyc();
    chk_rdy("bp_c_refused", 1'b0);
    chk_out("bp_still_a", 1'b1, 32'h123, 64'h123, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk_out("bp_b", 1'b1, 32'h22, 64'h22, 1'b0);
    chk_rdy("bp_ready_back", 1'b1);
    cyc();
    idle();
    chk_out("bp_c", 1'b1, 32'h456, 64'h456, 1'b0);
    cyc();
    chk_out("bp_empty", 1'b0, 32'h456, 64'h456, 1'b0);

    // Streaming: one item per cycle against the reference model
    for (int i = 0; i < 16; i++) begin
      w   = $urandom();
      src = 3'($urandom_range(0, 7));
      ref_imm(w, src, 1'b1, v64, il);
      ref_imm(w, src, 1'b0, v32, il32);
      exp_q64.push_back(v64);
      exp_q32.push_back(v32[31:0]);
      ill_q.push_back(il);
      drive(src, w);
      cyc();
      chk_rdy($sformatf("stream%0d", i), 1'b1);
      chk_out($sformatf("stream%0d", i), 1'b1, exp_q32.pop_front(),
              exp_q64.pop_front(), ill_q.pop_front());
    end
    idle();
    cyc();
    chk({"stream_end_valid"}, {63'b0, out_valid64 | out_valid32}, 64'h0);

    // Reset mid-flight with both stages full
    out_ready = 1'b0;
    drive(3'd0, 32'h0010_0000);
    cyc();
    drive(3'd0, 32'h0020_0000);
    cyc();
    idle();
    chk_rdy("full_before_rst", 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 64'h0, 1'b0);
    chk_rdy("async_rst", 1'b1);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk_out("post_rst1", 1'b0, 32'h0, 64'h0, 1'b0);
    cyc();
    chk_out("post_rst2", 1'b0, 32'h0, 64'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
